// File: rtl/round_key_xor_pipe.sv
// Purpose: AES round-key addition: XOR each block with a selectable slot from a loadable key bank.
// Latency: one cycle from accept to out_valid; a key write is visible to blocks accepted from the next edge on.
// Backpressure: an output register plus a skid register; in_ready comes only from registers (drops while the skid is full).
module round_key_xor_pipe #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 15,
    localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_we,
    input  logic [IDX_W-1:0]    key_idx,
    input  logic [DATA_W-1:0]   key_wdata,
    input  logic                key_clr,
    output logic [NUM_KEYS-1:0] keys_loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [IDX_W-1:0]    in_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err
);

    logic [DATA_W-1:0] key_mem [NUM_KEYS];

    logic [DATA_W-1:0] sel_key;
    logic              sel_loaded;
    logic [DATA_W-1:0] res_dat;
    logic              res_err;

    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic              skid_err;
    logic              accept;

    // The skid register is the only thing that can refuse input, so ready is a pure register output.
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & in_ready;

    // Key bank: clear beats write; slot indices outside the bank are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            keys_loaded <= '0;
        end else if (key_clr) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            keys_loaded <= '0;
        end else if (key_we) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_idx == IDX_W'(i)) begin
                    key_mem[i]     <= key_wdata;
                    keys_loaded[i] <= 1'b1;
                end
            end
        end
    end

    // Slot lookup reads the current register contents, so a same-cycle write is not seen (read-before-write).
    // An out-of-range index matches no slot: the key stays zero (data passes through) and the block is flagged.
    always_comb begin
        sel_key    = '0;
        sel_loaded = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (in_idx == IDX_W'(i)) begin
                sel_key    = key_mem[i];
                sel_loaded = keys_loaded[i];
            end
        end
        res_dat = in_data ^ sel_key;
        res_err = ~sel_loaded;
    end

    // Output/skid pair: the skid drains into OUT first; new results go to OUT when it frees up, otherwise to the skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            skid_vld  <= 1'b0;
            skid_dat  <= '0;
            skid_err  <= 1'b0;
        end else if (skid_vld) begin
            if (out_ready) begin
                out_data <= skid_dat;
                out_err  <= skid_err;
                skid_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= res_dat;
                out_err   <= res_err;
            end else begin
                skid_vld <= 1'b1;
                skid_dat <= res_dat;
                skid_err <= res_err;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_round_key_xor_pipe.sv
module tb_round_key_xor_pipe;

    localparam int DATA_W   = 128;
    localparam int NUM_KEYS = 15;
    localparam int IDX_W    = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                key_we;
    logic [IDX_W-1:0]    key_idx;
    logic [DATA_W-1:0]   key_wdata;
    logic                key_clr;
    logic [NUM_KEYS-1:0] keys_loaded;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data;
    logic [IDX_W-1:0]    in_idx;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_err;

    always #5 clk = ~clk;

    round_key_xor_pipe #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) dut (
        .clk(clk), .rst(rst),
        .key_we(key_we), .key_idx(key_idx), .key_wdata(key_wdata), .key_clr(key_clr),
        .keys_loaded(keys_loaded),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              e;
    } exp_t;

    exp_t                sb[$];
    logic [DATA_W-1:0]   mkey [NUM_KEYS];
    logic [NUM_KEYS-1:0] mloaded;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: key bank as an array; out-of-range slots pass data through and flag an error.
    function automatic exp_t model(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
        exp_t r;
        if (int'(i) < NUM_KEYS) begin
            r.d = d ^ mkey[i];
            r.e = !mloaded[i];
        end else begin
            r.d = d;
            r.e = 1'b1;
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_KEYS; i++) mkey[i] = '0;
        mloaded = '0;
    endtask

    // One clock: record any accept (using the key state before this edge's write), update the model, advance.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (acc) sb.push_back(model(in_data, in_idx));
        if (key_clr) begin
            model_clear();
        end else if (key_we && int'(key_idx) < NUM_KEYS) begin
            mkey[key_idx]    = key_wdata;
            mloaded[key_idx] = 1'b1;
        end
        @(posedge clk);
        #1;
        key_we  = 1'b0;
        key_clr = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_idx   = i;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: block %0h not accepted within 50 cycles", d);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks that stalled outputs hold still.
    initial begin
        logic              hold_pend;
        logic [DATA_W-1:0] hold_dat;
        logic              hold_err;
        exp_t              e;
        hold_pend = 1'b0;
        hold_dat  = '0;
        hold_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    chk("hold_data", out_data, hold_dat);
                    chk("hold_err", out_err, hold_err);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h with no block outstanding", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_data", out_data, e.d);
                        chk("sb_err", out_err, e.e);
                    end
                end
                hold_pend = out_valid && !out_ready;
                hold_dat  = out_data;
                hold_err  = out_err;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                acc;
        int                k;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] b [4];
        logic [DATA_W-1:0] ones;

        rst = 1'b1;
        key_we = 1'b0; key_idx = '0; key_wdata = '0; key_clr = 1'b0;
        in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b0;
        model_clear();
        ones = '1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_keys_loaded", keys_loaded, 0);
        rst = 1'b0;

        // FIPS-197 round 0
        out_ready = 1'b1;
        key_we = 1'b1; key_idx = 0; key_wdata = 128'h000102030405060708090a0b0c0d0e0f;
        step(acc);
        send(128'h00112233445566778899aabbccddeeff, 0);
        chk("fips_valid", out_valid, 1);
        chk("fips_data", out_data, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("fips_err", out_err, 0);
        chk("fips_loaded", keys_loaded, 15'h0001);

        // Read-before-write on slot 3
        key_we = 1'b1; key_idx = 3; key_wdata = ones;
        step(acc);
        key_we = 1'b1; key_idx = 3; key_wdata = '0;
        d = rnd_blk();
        send(d, 3);
        chk("rbw_old_key", out_data, d ^ ones);
        chk("rbw_old_err", out_err, 0);
        d = rnd_blk();
        send(d, 3);
        chk("rbw_new_key", out_data, d);
        chk("rbw_loaded", keys_loaded, 15'h0009);

        // Error paths
        d = rnd_blk();
        send(d, 15);
        chk("oor_data", out_data, d);
        chk("oor_err", out_err, 1);
        d = rnd_blk();
        send(d, 5);
        chk("unloaded_data", out_data, d);
        chk("unloaded_err", out_err, 1);
        key_clr = 1'b1; key_we = 1'b1; key_idx = 7; key_wdata = ones;
        step(acc);
        chk("clr_we_loaded", keys_loaded, 0);
        d = rnd_blk();
        send(d, 0);
        chk("cleared_data", out_data, d);
        chk("cleared_err", out_err, 1);

        // Backpressure / skid
        step(acc);
        step(acc);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = rnd_blk();
        k = 0;
        in_valid = 1'b1;
        in_idx = 0;
        repeat (4) begin
            in_data = b[(k < 4) ? k : 3];
            step(acc);
            if (acc) k++;
        end
        chk("bp_accepts", k, 2);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        repeat (4) begin
            chk("refill_valid", out_valid, 1);
            in_valid = (k < 4);
            in_data  = b[(k < 4) ? k : 3];
            step(acc);
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("refill_accepts", k, 4);

        // Random traffic with random stalls and key churn
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = rnd_blk();
            in_idx    = IDX_W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            key_we    = ($urandom_range(0, 5) == 0);
            key_idx   = IDX_W'($urandom_range(0, 15));
            key_wdata = rnd_blk();
            key_clr   = ($urandom_range(0, 80) == 0);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 10 && sb.size() != 0; n++) step(acc);
        step(acc);
        chk("drain_empty", sb.size(), 0);
        chk("drain_valid", out_valid, 0);

        // Reset mid-stream with both registers occupied
        key_we = 1'b1; key_idx = 2; key_wdata = rnd_blk();
        step(acc);
        out_ready = 1'b0;
        send(rnd_blk(), 2);
        send(rnd_blk(), 2);
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) step(acc);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_loaded", keys_loaded, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
